// File: rtl/m_sequencer.sv
// m_sequencer: control FSM for the M-extension unit, driving the m_registers mux selects.
// Optional macro M_DIV_ZERO_FAST_EN: divide by zero skips the iteration and raises div_by_zero.
`ifndef M_SEQUENCER_MUX_DEFS
`define M_SEQUENCER_MUX_DEFS
`define MUX_A_LENGTH 2
`define MUX_B_LENGTH 2
`define MUX_R_LENGTH 3
`define MUX_D_LENGTH 2
`define MUX_Z_LENGTH 2
`define MUX_A_ZERO       2'd0
`define MUX_A_R_UNSIGNED 2'd1
`define MUX_A_R_SIGNED   2'd2
`define MUX_B_ZERO       2'd0
`define MUX_B_D_UNSIGNED 2'd1
`define MUX_B_D_SIGNED   2'd2
`define MUX_R_KEEP       3'd0
`define MUX_R_A          3'd1
`define MUX_R_A_NEG      3'd2
`define MUX_R_MULT_LOWER 3'd3
`define MUX_R_SUB_KEEP   3'd4
`define MUX_D_KEEP       2'd0
`define MUX_D_B          2'd1
`define MUX_D_B_NEG      2'd2
`define MUX_D_SHR        2'd3
`define MUX_Z_KEEP       2'd0
`define MUX_Z_ZERO       2'd1
`define MUX_Z_MULT_UPPER 2'd2
`define MUX_Z_SHL_ADD    2'd3
`endif

// state         | meaning
// S_IDLE        | waiting for start; muxes at rest
// S_LOAD        | operands into R/D (negated for signed divide), Z cleared
// S_MUL_WAIT    | DSP pipeline filling, down-counter from MUL_LATENCY+1
// S_MUL_CAPTURE | product halves into R (lower) and Z (upper)
// S_DIV_ITER    | 32 restoring-divide steps, counter 0..31
// S_DONE        | one-cycle done pulse, registers hold
module m_sequencer #(
  parameter int MUL_LATENCY = 3
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     start,
  input  logic [2:0]               funct3,
  input  logic                     rs1_sign,
  input  logic                     rs2_sign,
  input  logic                     rs2_zero,
  input  logic                     sub_neg,
  output logic [`MUX_A_LENGTH-1:0] mux_A,
  output logic [`MUX_B_LENGTH-1:0] mux_B,
  output logic [`MUX_R_LENGTH-1:0] mux_R,
  output logic [`MUX_D_LENGTH-1:0] mux_D,
  output logic [`MUX_Z_LENGTH-1:0] mux_Z,
  output logic                     busy,
  output logic                     done,
  output logic                     result_sel,
  output logic                     negate_q,
  output logic                     negate_r,
  output logic                     div_by_zero
);

  typedef enum logic [2:0] {
    S_IDLE, S_LOAD, S_MUL_WAIT, S_MUL_CAPTURE, S_DIV_ITER, S_DONE
  } state_t;

  localparam logic [4:0] MUL_WAIT_LOAD = 5'(MUL_LATENCY + 1);

  state_t     state_q, state_d;
  logic [4:0] cnt_q, cnt_d;
  logic [2:0] funct3_q, funct3_d;
  logic       negq_q, negq_d;
  logic       negr_q, negr_d;
  logic       dbz_q, dbz_d;
  logic       rs2_neg_q, rs2_neg_d;
  logic       signed_div_in;
  logic       accept_dbz;
  logic       mul_a_signed;
  logic       mul_b_signed;
  logic       unused_sub_neg;

  assign unused_sub_neg = sub_neg;
  assign signed_div_in  = funct3[2] & ~funct3[0];

`ifdef M_DIV_ZERO_FAST_EN
  assign accept_dbz = funct3[2] & rs2_zero;
`else
  assign accept_dbz = 1'b0;
`endif

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q   <= S_IDLE;
      cnt_q     <= '0;
      funct3_q  <= '0;
      negq_q    <= 1'b0;
      negr_q    <= 1'b0;
      dbz_q     <= 1'b0;
      rs2_neg_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      funct3_q  <= funct3_d;
      negq_q    <= negq_d;
      negr_q    <= negr_d;
      dbz_q     <= dbz_d;
      rs2_neg_q <= rs2_neg_d;
    end
  end

  always_comb begin
    state_d      = state_q;
    cnt_d        = cnt_q;
    funct3_d     = funct3_q;
    negq_d       = negq_q;
    negr_d       = negr_q;
    dbz_d        = dbz_q;
    rs2_neg_d    = rs2_neg_q;
    mux_A        = `MUX_A_ZERO;
    mux_B        = `MUX_B_ZERO;
    mux_R        = `MUX_R_KEEP;
    mux_D        = `MUX_D_KEEP;
    mux_Z        = `MUX_Z_KEEP;
    mul_a_signed = (funct3_q == 3'b001) || (funct3_q == 3'b010);
    mul_b_signed = (funct3_q == 3'b001);
    case (state_q)
      S_IDLE: begin
        if (start) begin
          state_d   = S_LOAD;
          funct3_d  = funct3;
          negq_d    = signed_div_in & (rs1_sign ^ rs2_sign) & ~rs2_zero;
          negr_d    = signed_div_in & rs1_sign & ~accept_dbz;
          dbz_d     = accept_dbz;
          rs2_neg_d = signed_div_in & rs2_sign;
        end
      end
      S_LOAD: begin
        if (funct3_q[2]) begin
          // negr_q already excludes the fast divide-by-zero case, which loads A unsigned
          mux_R   = negr_q ? `MUX_R_A_NEG : `MUX_R_A;
          mux_D   = rs2_neg_q ? `MUX_D_B_NEG : `MUX_D_B;
          mux_Z   = `MUX_Z_ZERO;
          cnt_d   = '0;
          state_d = dbz_q ? S_DONE : S_DIV_ITER;
        end else begin
          mux_R   = `MUX_R_A;
          mux_D   = `MUX_D_B;
          cnt_d   = MUL_WAIT_LOAD;
          state_d = S_MUL_WAIT;
        end
      end
      S_MUL_WAIT: begin
        mux_A = mul_a_signed ? `MUX_A_R_SIGNED : `MUX_A_R_UNSIGNED;
        mux_B = mul_b_signed ? `MUX_B_D_SIGNED : `MUX_B_D_UNSIGNED;
        if (cnt_q == 5'd0) state_d = S_MUL_CAPTURE;
        else               cnt_d   = cnt_q - 5'd1;
      end
      S_MUL_CAPTURE: begin
        // A/B selects stay put: the upper product word depends on operand signedness
        mux_A   = mul_a_signed ? `MUX_A_R_SIGNED : `MUX_A_R_UNSIGNED;
        mux_B   = mul_b_signed ? `MUX_B_D_SIGNED : `MUX_B_D_UNSIGNED;
        mux_R   = `MUX_R_MULT_LOWER;
        mux_Z   = `MUX_Z_MULT_UPPER;
        state_d = S_DONE;
      end
      S_DIV_ITER: begin
        mux_R = `MUX_R_SUB_KEEP;
        mux_D = `MUX_D_SHR;
        mux_Z = `MUX_Z_SHL_ADD;
        cnt_d = cnt_q + 5'd1;
        if (cnt_q == 5'd31) state_d = S_DONE;
      end
      S_DONE:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  assign busy        = (state_q != S_IDLE);
  assign done        = (state_q == S_DONE);
  assign result_sel  = funct3_q[2] ? ~funct3_q[1] : (funct3_q[1:0] != 2'b00);
  assign negate_q    = negq_q;
  assign negate_r    = negr_q;
  assign div_by_zero = dbz_q;

endmodule

// File: tb/tb_m_sequencer.sv
// tb_m_sequencer: randomized self-checking bench for m_sequencer against a schedule-level model.
// Honors M_DIV_ZERO_FAST_EN the same way as the design.
module tb_m_sequencer;
  localparam int MUL_LATENCY = 3;
`ifdef M_DIV_ZERO_FAST_EN
  localparam bit FAST = 1'b1;
`else
  localparam bit FAST = 1'b0;
`endif

  localparam logic [1:0] A_ZERO = 2'd0, A_RU = 2'd1, A_RS = 2'd2;
  localparam logic [1:0] B_ZERO = 2'd0, B_DU = 2'd1, B_DS = 2'd2;
  localparam logic [2:0] R_KEEP = 3'd0, R_A = 3'd1, R_ANEG = 3'd2, R_MLO = 3'd3, R_SUB = 3'd4;
  localparam logic [1:0] D_KEEP = 2'd0, D_B = 2'd1, D_BNEG = 2'd2, D_SHR = 2'd3;
  localparam logic [1:0] Z_KEEP = 2'd0, Z_ZERO = 2'd1, Z_MHI = 2'd2, Z_SHL = 2'd3;
  localparam logic [12:0] IDLE_VEC = {1'b0, 1'b0, A_ZERO, B_ZERO, R_KEEP, D_KEEP, Z_KEEP};
  localparam logic [12:0] AB_MASK  = 13'h0780;

  logic       clk = 1'b0;
  logic       reset, start, rs1_sign, rs2_sign, rs2_zero, sub_neg;
  logic [2:0] funct3;
  logic [1:0] mux_A, mux_B, mux_D, mux_Z;
  logic [2:0] mux_R;
  logic       busy, done, result_sel, negate_q, negate_r, div_by_zero;
  logic [12:0] obs;
  logic [3:0]  obs_flags;
  int cyc = 0;
  int vectors = 0;
  int miscompares = 0;

  m_sequencer #(.MUL_LATENCY(MUL_LATENCY)) dut (
    .clk(clk), .reset(reset), .start(start), .funct3(funct3),
    .rs1_sign(rs1_sign), .rs2_sign(rs2_sign), .rs2_zero(rs2_zero), .sub_neg(sub_neg),
    .mux_A(mux_A), .mux_B(mux_B), .mux_R(mux_R), .mux_D(mux_D), .mux_Z(mux_Z),
    .busy(busy), .done(done), .result_sel(result_sel),
    .negate_q(negate_q), .negate_r(negate_r), .div_by_zero(div_by_zero)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;
  assign obs       = {busy, done, mux_A, mux_B, mux_R, mux_D, mux_Z};
  assign obs_flags = {result_sel, negate_q, negate_r, div_by_zero};

  initial begin
    #2000000;
    $display("FAIL timeout: simulation did not finish, required completion");
    $fatal(1);
  end

  function automatic int model_latency(input logic [2:0] f3, input logic z);
    if (!f3[2]) return MUL_LATENCY + 5;
    if (FAST && z) return 2;
    return 34;
  endfunction

  function automatic logic [3:0] model_flags(input logic [2:0] f3, input logic s1, s2, z);
    logic [7:0] rsel_tab = 8'b0011_1110;
    bit sdiv = (f3 == 3'd4) || (f3 == 3'd6);
    bit dz = FAST && f3[2] && z;
    return {rsel_tab[f3], sdiv && (s1 != s2) && !z, sdiv && s1 && !dz, dz};
  endfunction

  // {care_ab, busy, done, a, b, r, d, z} for cycle T+k of an op accepted at T
  function automatic logic [13:0] model_step(input logic [2:0] f3, input logic s1, s2, z, input int k);
    int lat = model_latency(f3, z);
    bit sdiv = (f3 == 3'd4) || (f3 == 3'd6);
    bit dz = FAST && f3[2] && z;
    bit care = 1'b1;
    logic [1:0] a = A_ZERO, b = B_ZERO, d = D_KEEP, zq = Z_KEEP;
    logic [2:0] r = R_KEEP;
    if (k == 1) begin
      care = 1'b0;
      if (f3[2]) begin
        r = (sdiv && s1 && !dz) ? R_ANEG : R_A;
        d = (sdiv && s2) ? D_BNEG : D_B;
        zq = Z_ZERO;
      end else begin
        r = R_A;
        d = D_B;
      end
    end else if (k == lat) begin
      care = 1'b0;
    end else if (!f3[2]) begin
      a = (f3 == 3'd1 || f3 == 3'd2) ? A_RS : A_RU;
      b = (f3 == 3'd1) ? B_DS : B_DU;
      if (k == lat - 1) begin
        r = R_MLO;
        zq = Z_MHI;
      end
    end else begin
      r = R_SUB;
      d = D_SHR;
      zq = Z_SHL;
    end
    return {care, 1'b1, (k == lat), a, b, r, d, zq};
  endfunction

  // noise: 0 = start low while busy, 1 = random start/fields, 2 = start held high with random fields
  task automatic run_op(input logic [2:0] f3, input logic s1, s2, z, input int noise,
                        output int t_acc, output int t_done);
    int lat, guard;
    logic [13:0] e;
    logic [12:0] m;
    logic [3:0]  ef;
    guard = 0;
    while (busy !== 1'b0 && guard < 50) begin
      @(negedge clk);
      guard++;
    end
    if (guard >= 50) begin
      vectors++; miscompares++;
      $display("FAIL idle_wait: busy=%b after %0d cycles, required 0", busy, guard);
    end
    start = 1'b1; funct3 = f3; rs1_sign = s1; rs2_sign = s2; rs2_zero = z;
    t_acc = cyc; t_done = -1;
    lat = model_latency(f3, z);
    ef  = model_flags(f3, s1, s2, z);
    for (int k = 1; k <= lat; k++) begin
      @(posedge clk);
      #1;
      if (noise != 0) begin
        start    = (noise == 2) ? 1'b1 : 1'($urandom_range(0, 1));
        funct3   = 3'($urandom);
        rs1_sign = 1'($urandom);
        rs2_sign = 1'($urandom);
        rs2_zero = 1'($urandom);
      end else begin
        start = 1'b0;
      end
      @(negedge clk);
      if (done === 1'b1 && t_done < 0) t_done = cyc;
      e = model_step(f3, s1, s2, z, k);
      m = e[13] ? 13'h1fff : ~AB_MASK;
      vectors++;
      if ((obs & m) !== (e[12:0] & m)) begin
        miscompares++;
        $display("FAIL trace f3=%0d k=%0d: got %h required %h (mask %h)", f3, k, obs, e[12:0], m);
      end
      vectors++;
      if (obs_flags !== ef) begin
        miscompares++;
        $display("FAIL flags f3=%0d k=%0d: got %b required %b", f3, k, obs_flags, ef);
      end
    end
  endtask

  task automatic test_reset;
    reset = 1'b1; start = 1'b0; funct3 = '0; rs1_sign = 0; rs2_sign = 0; rs2_zero = 0; sub_neg = 0;
    repeat (3) @(negedge clk);
    vectors++;
    if ({obs, obs_flags} !== {IDLE_VEC, 4'b0}) begin
      miscompares++;
      $display("FAIL reset_state: got %h/%b required %h/0000", obs, obs_flags, IDLE_VEC);
    end
    reset = 1'b0;
    @(negedge clk);
    vectors++;
    if ({obs, obs_flags} !== {IDLE_VEC, 4'b0}) begin
      miscompares++;
      $display("FAIL idle_after_reset: got %h/%b required %h/0000", obs, obs_flags, IDLE_VEC);
    end
  endtask

  task automatic test_reset_mid_div;
    int pulses, busy_seen;
    start = 1'b1; funct3 = 3'd4; rs1_sign = 1; rs2_sign = 1; rs2_zero = 0;
    @(posedge clk); #1 start = 1'b0;
    repeat (10) @(negedge clk);
    vectors++;
    if (busy !== 1'b1 || mux_Z !== Z_SHL) begin
      miscompares++;
      $display("FAIL mid_div_busy: got busy=%b mux_Z=%0d required 1/%0d", busy, mux_Z, Z_SHL);
    end
    @(posedge clk); #1 reset = 1'b1;
    repeat (3) @(posedge clk);
    #1 reset = 1'b0;
    @(negedge clk);
    vectors++;
    if ({obs, obs_flags} !== {IDLE_VEC, 4'b0}) begin
      miscompares++;
      $display("FAIL abort_state: got %h/%b required %h/0000", obs, obs_flags, IDLE_VEC);
    end
    pulses = 0; busy_seen = 0;
    repeat (40) begin
      @(negedge clk);
      if (done === 1'b1) pulses++;
      if (busy !== 1'b0) busy_seen++;
    end
    vectors++;
    if (pulses != 0 || busy_seen != 0) begin
      miscompares++;
      $display("FAIL abort_quiet: got done_pulses=%0d busy_cycles=%0d required 0/0", pulses, busy_seen);
    end
  endtask

  task automatic test_mulhu;
    int ta, td;
    run_op(3'd3, 1'b1, 1'b1, 1'b0, 0, ta, td);
    vectors++;
    if (td - ta != 8) begin
      miscompares++;
      $display("FAIL mulhu_latency: got %0d required 8", td - ta);
    end
    vectors++;
    if (result_sel !== 1'b1) begin
      miscompares++;
      $display("FAIL mulhu_result_sel: got %b required 1", result_sel);
    end
    @(negedge clk);
    vectors++;
    if ({obs, obs_flags} !== {IDLE_VEC, 4'b1000}) begin
      miscompares++;
      $display("FAIL mulhu_idle_hold: got %h/%b required %h/1000", obs, obs_flags, IDLE_VEC);
    end
  endtask

  task automatic test_mulhsu_mul;
    int ta, td;
    run_op(3'd2, 1'b1, 1'b0, 1'b0, 0, ta, td);
    run_op(3'd0, 1'b1, 1'b1, 1'b0, 0, ta, td);
    vectors++;
    if (result_sel !== 1'b0 || td - ta != MUL_LATENCY + 5) begin
      miscompares++;
      $display("FAIL mul_result: got sel=%b lat=%0d required 0/%0d", result_sel, td - ta, MUL_LATENCY + 5);
    end
  endtask

  task automatic test_div_signed;
    int ta, td;
    run_op(3'd4, 1'b1, 1'b0, 1'b0, 0, ta, td);
    vectors++;
    if (td - ta != 34 || negate_q !== 1'b1 || negate_r !== 1'b1) begin
      miscompares++;
      $display("FAIL div_neg7_2: got lat=%0d nq=%b nr=%b required 34/1/1", td - ta, negate_q, negate_r);
    end
    run_op(3'd4, 1'b1, 1'b1, 1'b0, 0, ta, td);
    vectors++;
    if (negate_q !== 1'b0 || result_sel !== 1'b1) begin
      miscompares++;
      $display("FAIL div_overflow: got nq=%b sel=%b required 0/1", negate_q, result_sel);
    end
  endtask

  task automatic test_remu_zero;
    int ta, td, want;
    want = 34;
`ifdef M_DIV_ZERO_FAST_EN
    want = 2;
`endif
    run_op(3'd7, 1'($urandom), 1'b0, 1'b1, 0, ta, td);
    vectors++;
    if (td - ta != want || negate_q !== 1'b0) begin
      miscompares++;
      $display("FAIL remu_zero: got lat=%0d nq=%b required %0d/0", td - ta, negate_q, want);
    end
    run_op(3'd6, 1'b1, 1'b0, 1'b1, 0, ta, td);
    start = 1'b0;
  endtask

  task automatic test_back_to_back;
    int a1, d1, a2, d2, a3, d3;
    run_op(3'd1, 1'b1, 1'b0, 1'b0, 2, a1, d1);
    run_op(3'd5, 1'b0, 1'b1, 1'b0, 2, a2, d2);
    run_op(3'd3, 1'b1, 1'b1, 1'b0, 0, a3, d3);
    vectors++;
    if (a2 != d1 + 1 || a3 != d2 + 1) begin
      miscompares++;
      $display("FAIL back_to_back: got accept gaps %0d,%0d required 1,1", a2 - d1, a3 - d2);
    end
    start = 1'b0;
  endtask

  task automatic test_random;
    int ta, td;
    logic [2:0] f3;
    logic s1, s2, z;
    for (int n = 0; n < 25; n++) begin
      f3 = 3'($urandom);
      s1 = 1'($urandom);
      s2 = 1'($urandom);
      z  = ($urandom_range(0, 3) == 0);
      run_op(f3, s1, s2, z, int'($urandom_range(0, 2)), ta, td);
      vectors++;
      if (td - ta != model_latency(f3, z)) begin
        miscompares++;
        $display("FAIL rand_latency f3=%0d z=%b: got %0d required %0d", f3, z, td - ta, model_latency(f3, z));
      end
    end
    start = 1'b0;
    @(negedge clk);
  endtask

  initial begin
    test_reset();
    test_reset_mid_div();
    test_mulhu();
    test_mulhsu_mul();
    test_div_signed();
    test_remu_zero();
    test_back_to_back();
    test_random();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule
